// File: rtl/mtx_pkg.sv
// Shared sizing and state encoding for the dot-product result collector.
// Element width, matrix dimension and tag width are fixed here for every user.
package mtx_pkg;

   localparam int DIM      = 8;
   localparam int DATA_W   = 32;
   localparam int NUM_ELEM = DIM * DIM;
   localparam int TAG_W    = $clog2(NUM_ELEM);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2
   } state_t;

endpackage

// File: rtl/mtx_result_ram.sv
// Result-matrix storage: one synchronous write port, one asynchronous read port.
// Contents carry no reset; the collector's bitmap decides what is valid.
module mtx_result_ram
   import mtx_pkg::*;
#(
   parameter int WIDTH  = DATA_W,
   parameter int DEPTH  = NUM_ELEM,
   parameter int ADDR_W = TAG_W
)
(
   input  logic              i_clock,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WIDTH-1:0]  i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WIDTH-1:0]  o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Asynchronous read so a write on one edge is visible on the stream right after.
   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mtx_result_collector.sv
// Collects 64 tagged dot-product results into an 8x8 buffer, then streams it row-major.
// Optional running checksum output enabled by defining MTX_COLLECT_CHECKSUM_EN.
module mtx_result_collector
   import mtx_pkg::*;
(
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              START,
   input  logic              RES_VALID,
   input  logic [DATA_W-1:0] RES_DATA,
   input  logic [TAG_W-1:0]  RES_DEST,
   output logic [DATA_W-1:0] M_AXIS_TDATA,
   output logic              M_AXIS_TVALID,
   input  logic              M_AXIS_TREADY,
   output logic              M_AXIS_TLAST,
   output logic              BUSY,
   output logic              DONE,
`ifdef MTX_COLLECT_CHECKSUM_EN
   output logic [DATA_W-1:0] CHECKSUM,
`endif
   output logic              ERR
);

   localparam logic [TAG_W-1:0] LAST_IDX   = TAG_W'(NUM_ELEM - 1);
   localparam logic [TAG_W-1:0] IDX_ONE    = TAG_W'(1);
   localparam logic [TAG_W:0]   CNT_PENULT = (TAG_W + 1)'(NUM_ELEM - 1);
   localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W + 1)'(1);

   state_t              r_state;
   state_t              w_stateNext;
   logic [NUM_ELEM-1:0] r_bitmap;
   logic [TAG_W:0]      r_count;
   logic [TAG_W-1:0]    r_idx;
   logic                r_err;
   logic                r_done;
   logic [DATA_W-1:0]   w_rdData;
   logic                w_write;
   logic                w_fresh;
   logic                w_handshake;
   logic                w_lastBeat;
   logic                w_stray;

   // START always wins, so a result or handshake coinciding with it is dropped.
   assign w_write     = (r_state == COLLECT) && RES_VALID && !START;
   assign w_fresh     = w_write && !r_bitmap[RES_DEST];
   assign w_handshake = (r_state == DRAIN) && M_AXIS_TREADY && !START;
   assign w_lastBeat  = w_handshake && (r_idx == LAST_IDX);
   assign w_stray     = RES_VALID && !START && (r_state != COLLECT);

   mtx_result_ram #(
      .WIDTH  (DATA_W),
      .DEPTH  (NUM_ELEM),
      .ADDR_W (TAG_W)
   ) u_ram (
      .i_clock (ACLK),
      .i_we    (w_write),
      .i_waddr (RES_DEST),
      .i_wdata (RES_DATA),
      .i_raddr (r_idx),
      .o_rdata (w_rdData)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE: begin
            if (START) begin
               w_stateNext = COLLECT;
            end
         end
         COLLECT: begin
            if (START) begin
               w_stateNext = COLLECT;
            end else if (w_fresh && (r_count == CNT_PENULT)) begin
               w_stateNext = DRAIN;
            end
         end
         DRAIN: begin
            if (START) begin
               w_stateNext = COLLECT;
            end else if (w_lastBeat) begin
               w_stateNext = IDLE;
            end
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

   // Completion bitmap, unique-entry count, read index and sticky error.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_bitmap <= '0;
         r_count  <= '0;
         r_idx    <= '0;
         r_err    <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= w_lastBeat;
         if (START) begin
            r_bitmap <= '0;
            r_count  <= '0;
            r_idx    <= '0;
            r_err    <= 1'b0;
         end else begin
            if (w_write) begin
               if (r_bitmap[RES_DEST]) begin
                  r_err <= 1'b1;
               end else begin
                  r_bitmap[RES_DEST] <= 1'b1;
                  r_count            <= r_count + CNT_ONE;
               end
            end
            if (w_stray) begin
               r_err <= 1'b1;
            end
            if (w_handshake) begin
               r_idx <= w_lastBeat ? '0 : (r_idx + IDX_ONE);
            end
            if (w_lastBeat) begin
               r_count <= '0;
            end
         end
      end
   end

`ifdef MTX_COLLECT_CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   // Duplicates are summed again; no writes happen outside COLLECT so it holds through DRAIN.
   always_ff @(posedge ACLK) begin
      if (ARESET || START) begin
         r_checksum <= '0;
      end else if (w_write) begin
         r_checksum <= r_checksum + RES_DATA;
      end
   end

   assign CHECKSUM = r_checksum;
`endif

   assign M_AXIS_TVALID = (r_state == DRAIN);
   assign M_AXIS_TDATA  = (r_state == DRAIN) ? w_rdData : '0;
   assign M_AXIS_TLAST  = (r_state == DRAIN) && (r_idx == LAST_IDX);
   assign BUSY          = (r_state != IDLE);
   assign DONE          = r_done;
   assign ERR           = r_err;

endmodule

// File: tb/tb_mtx_result_collector.sv
// Self-checking bench for mtx_result_collector against a plain array/flag reference model.
// Define MTX_COLLECT_CHECKSUM_EN to also check the running checksum output.
module tb_mtx_result_collector;
   import mtx_pkg::*;

   logic              ACLK = 1'b0;
   logic              ARESET;
   logic              START;
   logic              RES_VALID;
   logic [DATA_W-1:0] RES_DATA;
   logic [TAG_W-1:0]  RES_DEST;
   logic [DATA_W-1:0] M_AXIS_TDATA;
   logic              M_AXIS_TVALID;
   logic              M_AXIS_TREADY;
   logic              M_AXIS_TLAST;
   logic              BUSY;
   logic              DONE;
   logic              ERR;
`ifdef MTX_COLLECT_CHECKSUM_EN
   logic [DATA_W-1:0] CHECKSUM;
`endif

   mtx_result_collector dut (
      .ACLK          (ACLK),
      .ARESET        (ARESET),
      .START         (START),
      .RES_VALID     (RES_VALID),
      .RES_DATA      (RES_DATA),
      .RES_DEST      (RES_DEST),
      .M_AXIS_TDATA  (M_AXIS_TDATA),
      .M_AXIS_TVALID (M_AXIS_TVALID),
      .M_AXIS_TREADY (M_AXIS_TREADY),
      .M_AXIS_TLAST  (M_AXIS_TLAST),
      .BUSY          (BUSY),
      .DONE          (DONE),
`ifdef MTX_COLLECT_CHECKSUM_EN
      .CHECKSUM      (CHECKSUM),
`endif
      .ERR           (ERR)
   );

   always #5 ACLK = ~ACLK;

   int nChecks = 0;
   int nBad    = 0;

   // Reference model: what the matrix should hold, which entries are filled, sticky error.
   logic [DATA_W-1:0] refMem [NUM_ELEM];
   bit                refSeen [NUM_ELEM];
   int                refUnique;
   bit                refErr;
   logic [DATA_W-1:0] refSum;
   int                perm [NUM_ELEM];

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nBad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic modelClear();
      for (int i = 0; i < NUM_ELEM; i++) refSeen[i] = 1'b0;
      refUnique = 0;
      refErr    = 1'b0;
      refSum    = '0;
   endtask

   task automatic shufflePerm();
      for (int i = 0; i < NUM_ELEM; i++) perm[i] = i;
      for (int i = NUM_ELEM - 1; i > 0; i--) begin
         int j;
         int t;
         j       = int'($urandom_range(0, i));
         t       = perm[i];
         perm[i] = perm[j];
         perm[j] = t;
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, ".tvalid"}, M_AXIS_TVALID, 0);
      checkOutput({tag, ".tlast"}, M_AXIS_TLAST, 0);
      checkOutput({tag, ".tdata"}, M_AXIS_TDATA, 0);
      checkOutput({tag, ".busy"}, BUSY, 0);
      checkOutput({tag, ".done"}, DONE, 0);
      checkOutput({tag, ".err"}, ERR, 0);
   endtask

   task automatic applyStart();
      START = 1'b1;
      tick();
      START = 1'b0;
      modelClear();
      checkOutput("start.busy", BUSY, 1);
      checkOutput("start.tvalid", M_AXIS_TVALID, 0);
      checkOutput("start.err", ERR, 0);
   endtask

   // Deliver one result while collecting and compare the visible status afterwards.
   task automatic applyStimulus(input int dest, input logic [DATA_W-1:0] data);
      RES_VALID = 1'b1;
      RES_DEST  = TAG_W'(dest);
      RES_DATA  = data;
      tick();
      RES_VALID = 1'b0;
      if (refSeen[dest]) begin
         refErr = 1'b1;
      end else begin
         refSeen[dest] = 1'b1;
         refUnique++;
      end
      refMem[dest] = data;
      refSum       = refSum + data;
      checkOutput($sformatf("write%0d.tvalid", dest), M_AXIS_TVALID, (refUnique == NUM_ELEM));
      checkOutput($sformatf("write%0d.err", dest), ERR, refErr);
      checkOutput($sformatf("write%0d.busy", dest), BUSY, 1);
   endtask

   // readyMode: 0 always ready, 1 toggling, 2 random. injectAt/abortAt are beat numbers or -1.
   task automatic drainStream(input int readyMode, input int injectAt, input int abortAt);
      int beat   = 0;
      int cycles = 0;
      bit injected = 1'b0;
      bit ready;
      while (beat < NUM_ELEM && cycles < 1000) begin
         cycles++;
         if (beat == abortAt) begin
            START         = 1'b1;
            M_AXIS_TREADY = 1'b0;
            tick();
            START = 1'b0;
            modelClear();
            checkOutput("abort.tvalid", M_AXIS_TVALID, 0);
            checkOutput("abort.busy", BUSY, 1);
            checkOutput("abort.err", ERR, 0);
            checkOutput("abort.done", DONE, 0);
            return;
         end
         case (readyMode)
            0:       ready = 1'b1;
            1:       ready = (cycles % 2) == 1;
            default: ready = 1'($urandom_range(0, 1));
         endcase
         if (beat == injectAt && !injected) begin
            RES_VALID = 1'b1;
            RES_DEST  = TAG_W'($urandom_range(0, NUM_ELEM - 1));
            RES_DATA  = $urandom;
            refErr    = 1'b1;
            injected  = 1'b1;
         end
         M_AXIS_TREADY = ready;
         checkOutput($sformatf("beat%0d.tvalid", beat), M_AXIS_TVALID, 1);
         checkOutput($sformatf("beat%0d.tdata", beat), M_AXIS_TDATA, refMem[beat]);
         checkOutput($sformatf("beat%0d.tlast", beat), M_AXIS_TLAST, (beat == NUM_ELEM - 1));
         if (ready) beat++;
         tick();
         RES_VALID = 1'b0;
         if (beat < NUM_ELEM) begin
            checkOutput("drain.done", DONE, 0);
         end
      end
      M_AXIS_TREADY = 1'b0;
      if (beat < NUM_ELEM) begin
         checkOutput("drainTimeout", 0, 1);
         return;
      end
      checkOutput("end.done", DONE, 1);
      checkOutput("end.tvalid", M_AXIS_TVALID, 0);
      checkOutput("end.busy", BUSY, 0);
      checkOutput("end.err", ERR, refErr);
`ifdef MTX_COLLECT_CHECKSUM_EN
      checkOutput("end.checksum", CHECKSUM, refSum);
`endif
      tick();
      checkOutput("afterEnd.done", DONE, 0);
   endtask

   task automatic writeRandomMatrix();
      shufflePerm();
      for (int i = 0; i < NUM_ELEM; i++) applyStimulus(perm[i], $urandom);
   endtask

   initial begin
      ARESET        = 1'b1;
      START         = 1'b0;
      RES_VALID     = 1'b0;
      RES_DATA      = '0;
      RES_DEST      = '0;
      M_AXIS_TREADY = 1'b0;
      modelClear();
      repeat (3) tick();
      checkIdleOutputs("reset");
      ARESET = 1'b0;
      tick();

      // In-order fill, data = dest*3, always ready.
      applyStart();
      for (int d = 0; d < NUM_ELEM; d++) applyStimulus(d, DATA_W'(d * 3));
      drainStream(0, -1, -1);

      // START together with a result in IDLE: result dropped, no error.
      START     = 1'b1;
      RES_VALID = 1'b1;
      RES_DEST  = TAG_W'(7);
      RES_DATA  = $urandom;
      tick();
      START     = 1'b0;
      RES_VALID = 1'b0;
      modelClear();
      checkOutput("startWins.err", ERR, 0);
      checkOutput("startWins.busy", BUSY, 1);
      for (int d = NUM_ELEM - 1; d >= 0; d--) applyStimulus(d, DATA_W'(32'hA000 + d));
      drainStream(1, -1, -1);

      // Dest 5 written twice; second value must win and ERR must stick.
      begin
         int others [$];
         int pos;
         applyStart();
         shufflePerm();
         for (int i = 0; i < NUM_ELEM; i++) if (perm[i] != 5) others.push_back(perm[i]);
         pos = int'($urandom_range(0, NUM_ELEM - 3));
         others.insert(pos, 5);
         applyStimulus(5, DATA_W'(32'h11));
         foreach (others[i]) begin
            if (others[i] == 5) applyStimulus(5, DATA_W'(32'h22));
            else applyStimulus(others[i], $urandom);
         end
         checkOutput("dup.beat5", refMem[5], 32'h22);
         drainStream(2, -1, -1);
      end

      // Stray result in IDLE, then another mid-stream.
      RES_VALID = 1'b1;
      RES_DEST  = TAG_W'(3);
      RES_DATA  = $urandom;
      tick();
      RES_VALID = 1'b0;
      checkOutput("idleStray.err", ERR, 1);
      checkOutput("idleStray.busy", BUSY, 0);
      applyStart();
      writeRandomMatrix();
      drainStream(2, 10, -1);

      // Restart in the middle of the stream, then a full fresh matrix.
      applyStart();
      writeRandomMatrix();
      drainStream(0, -1, 20);
      writeRandomMatrix();
      drainStream(2, -1, -1);

      // Reset after 30 entries, then a full refill of ones.
      applyStart();
      shufflePerm();
      for (int i = 0; i < 30; i++) applyStimulus(perm[i], $urandom);
      ARESET = 1'b1;
      tick();
      ARESET = 1'b0;
      modelClear();
      checkIdleOutputs("midReset");
      applyStart();
      shufflePerm();
      for (int i = 0; i < NUM_ELEM; i++) applyStimulus(perm[i], DATA_W'(1));
      checkOutput("ones.sum", refSum, 64);
      drainStream(0, -1, -1);

      $display("test done: total=%0d bad=%0d", nChecks, nBad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
